// File: rtl/riscv_pkg.sv
// Shared RV32 types for the data-memory path: word width, access sizes and
// the data-memory arbiter state encoding.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } dmem_arb_state_t;

  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // One-hot strobe for a two-requester port.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer favours one requester on conflict
// and moves to the other side after every grant that is taken.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic r_ptr;

  // Grant selection: a lone request always wins, a conflict goes to the pointer.
  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = r_ptr ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // Pointer update: after a grant the loser becomes the favoured requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= 1'b0;
    end else if (advance_i && (gnt_o != 2'b00)) begin
      r_ptr <= gnt_o[0];
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core load/store path and the
// debug/DMA port; one transaction at a time, accept -> access -> respond.
module dmem_arbiter #(
  parameter int unsigned XLEN    = riscv_pkg::XLEN,
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_addr_i,
  input  logic [NUM_REQ-1:0][XLEN-1:0]      req_wdata_i,
  input  logic [NUM_REQ-1:0]                req_we_i,
  input  logic [NUM_REQ-1:0][1:0]           req_size_i,
  input  logic [NUM_REQ-1:0]                req_sign_ext_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [XLEN-1:0]                   rsp_rdata_o,
  output logic                              mem_write_en_o,
  output logic [XLEN-1:0]                   mem_addr_o,
  output logic [XLEN-1:0]                   mem_wdata_o,
  output logic [1:0]                        mem_size_o,
  output logic                              mem_sign_ext_o,
  input  logic [XLEN-1:0]                   mem_rdata_i
);

  import riscv_pkg::*;

  dmem_arb_state_t    r_state;
  logic               r_owner;
  logic [XLEN-1:0]    r_addr;
  logic [XLEN-1:0]    r_wdata;
  logic [1:0]         r_size;
  logic               r_sign_ext;
  logic               r_mem_we;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [XLEN-1:0]    r_rsp_rdata;

  logic [1:0] w_gnt;
  logic       w_idle;
  logic       w_accept;
  logic       w_sel;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && ((req_valid_i & w_gnt) != 2'b00);
  assign w_sel    = w_gnt[1];

  rr_arbiter2 u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (w_accept),
    .gnt_o     (w_gnt)
  );

  // Ready is the live grant while idle, held low while reset is asserted.
  always_comb begin
    if (w_idle && rst_ni) begin
      req_ready_o = w_gnt;
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Transaction FSM; the captured request doubles as the memory-port drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_addr      <= {XLEN{1'b0}};
      r_wdata     <= {XLEN{1'b0}};
      r_size      <= WORD;
      r_sign_ext  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_rdata <= {XLEN{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_rsp_valid <= 2'b00;
          if (w_accept) begin
            r_state    <= ACCESS;
            r_owner    <= w_sel;
            r_addr     <= req_addr_i[w_sel];
            r_wdata    <= req_wdata_i[w_sel];
            r_size     <= req_size_i[w_sel];
            r_sign_ext <= req_sign_ext_i[w_sel];
            r_mem_we   <= req_we_i[w_sel];
          end else begin
            r_state  <= IDLE;
            r_mem_we <= 1'b0;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= onehot2(r_owner);
          // Stores and illegal sizes return zero rather than bus garbage.
          if (r_mem_we || (r_size == SIZE_ILLEGAL)) begin
            r_rsp_rdata <= {XLEN{1'b0}};
          end else begin
            r_rsp_rdata <= mem_rdata_i;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 2'b00;
        end
        default: begin
          r_state     <= IDLE;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= 2'b00;
        end
      endcase
    end
  end

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_rdata_o    = r_rsp_rdata;
  assign mem_write_en_o = r_mem_we;
  assign mem_addr_o     = r_addr;
  assign mem_wdata_o    = r_wdata;
  assign mem_size_o     = r_size;
  assign mem_sign_ext_o = r_sign_ext;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-array data memory, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b1;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        req_we;
  logic [1:0][1:0]   req_size;
  logic [1:0]        req_sext;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [1:0]        mem_size;
  logic              mem_sext;
  logic [31:0]       mem_rdata;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int acc_cyc[$];
  int acc_own[$];
  int rsp1_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_sign_ext_i (req_sext),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .mem_write_en_o (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_size_o     (mem_size),
    .mem_sign_ext_o (mem_sext),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_bytes(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3,
                                           input logic [1:0] sz, input logic sx);
    case (sz)
      2'b00:   return sx ? {{24{b0[7]}}, b0} : {24'h000000, b0};
      2'b01:   return sx ? {{16{b1[7]}}, b1, b0} : {16'h0000, b1, b0};
      2'b10:   return {b3, b2, b1, b0};
      default: return 32'h00000000;
    endcase
  endfunction

  function automatic logic pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p;
    else if (v[0]) return 1'b0;
    else return 1'b1;
  endfunction

  // Environment memory: 64-byte window, little-endian, combinational read.
  logic [7:0] env_mem [64] = '{default: 8'h00};
  logic [5:0] ma, ma1, ma2, ma3;
  assign ma  = mem_addr[5:0];
  assign ma1 = ma + 6'd1;
  assign ma2 = ma + 6'd2;
  assign ma3 = ma + 6'd3;
  assign mem_rdata = ld_bytes(env_mem[ma], env_mem[ma1], env_mem[ma2], env_mem[ma3], mem_size, mem_sext);

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_size)
        2'b00: env_mem[ma] <= mem_wdata[7:0];
        2'b01: begin env_mem[ma] <= mem_wdata[7:0]; env_mem[ma1] <= mem_wdata[15:8]; end
        2'b10: begin
          env_mem[ma]  <= mem_wdata[7:0];   env_mem[ma1] <= mem_wdata[15:8];
          env_mem[ma2] <= mem_wdata[23:16]; env_mem[ma3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // Reference model: cycles since acceptance, favoured requester, last transaction.
  logic [7:0]  exp_mem [64] = '{default: 8'h00};
  int          m_phase;
  logic        m_prio, m_owner, m_we, m_sext;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_size;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_phase <= 0; m_prio <= 1'b0; m_owner <= 1'b0;
      m_addr <= 32'h0; m_wdata <= 32'h0; m_we <= 1'b0;
      m_size <= 2'b10; m_sext <= 1'b0; m_rdata <= 32'h0;
    end else if (m_phase == 0) begin
      if (req_valid != 2'b00) begin
        m_phase <= 1;
        m_owner <= pick(req_valid, m_prio);
        m_prio  <= ~pick(req_valid, m_prio);
        m_addr  <= req_addr[pick(req_valid, m_prio)];
        m_wdata <= req_wdata[pick(req_valid, m_prio)];
        m_we    <= req_we[pick(req_valid, m_prio)];
        m_size  <= req_size[pick(req_valid, m_prio)];
        m_sext  <= req_sext[pick(req_valid, m_prio)];
      end
    end else if (m_phase == 1) begin
      m_phase <= 2;
      if (m_we || m_size == 2'b11) m_rdata <= 32'h0;
      else m_rdata <= ld_bytes(exp_mem[m_addr[5:0]], exp_mem[m_addr[5:0] + 6'd1],
                               exp_mem[m_addr[5:0] + 6'd2], exp_mem[m_addr[5:0] + 6'd3],
                               m_size, m_sext);
      if (m_we) begin
        for (int b = 0; b < 4; b++) begin
          if ((m_size == 2'b10) || (m_size == 2'b01 && b < 2) || (m_size == 2'b00 && b == 0))
            exp_mem[m_addr[5:0] + 6'(b)] <= m_wdata[8*b +: 8];
        end
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready),
        32'((rst_ni && m_phase == 0 && req_valid != 2'b00) ? (pick(req_valid, m_prio) ? 2'b10 : 2'b01) : 2'b00));
    chk("rsp_valid", 32'(rsp_valid), 32'((m_phase == 2) ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("mem_we", 32'(mem_we), 32'((m_phase == 1) ? m_we : 1'b0));
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_size", 32'(mem_size), 32'(m_size));
    chk("mem_sext", 32'(mem_sext), 32'(m_sext));
  end

  // Acceptance and response log for spacing/ownership checks.
  always @(negedge clk) begin
    if ((req_valid & req_ready) != 2'b00) begin
      acc_cyc.push_back(cyc);
      acc_own.push_back(int'(req_ready[1]));
    end
    if (rsp_valid[1]) rsp1_cnt <= rsp1_cnt + 1;
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] wd,
                         input logic w, input logic [1:0] s, input logic sx);
    req_addr[i] = a; req_wdata[i] = wd; req_we[i] = w; req_size[i] = s; req_sext[i] = sx;
  endtask

  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic [1:0] s, input logic sx,
                        output logic [31:0] rd);
    logic ok;
    @(posedge clk); #1;
    set_req(i, a, wd, w, s, sx);
    req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; break; end
    end
    chk("accept_in_time", 32'(ok), 32'h1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk("we_at_N+1", 32'(mem_we), 32'(w));
    @(negedge clk);
    chk("rsp_at_N+2", 32'(rsp_valid), (i == 1) ? 32'h2 : 32'h1);
    rd = rsp_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int acc0, rsp1_0;
    req_valid = 2'b00;
    for (int i = 0; i < 2; i++) set_req(i, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_mem_size", 32'(mem_size), 32'h2);
    chk("reset_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;

    // Word store from the core path, then a signed byte load from debug.
    do_req(0, 32'h10000000, 32'hDEADBEEF, 1'b1, 2'b10, 1'b0, rd);
    chk("store_rdata", rd, 32'h0);
    chk("mem_word0", {env_mem[3], env_mem[2], env_mem[1], env_mem[0]}, 32'hDEADBEEF);
    do_req(1, 32'h10000003, 32'h0, 1'b0, 2'b00, 1'b1, rd);
    chk("lb_rdata", rd, 32'hFFFFFFDE);

    // Illegal size: forwarded, no effect, zero data.
    do_req(0, 32'h10000000, 32'h0, 1'b0, 2'b11, 1'b0, rd);
    chk("size11_rdata", rd, 32'h0);
    chk("size11_mem", {env_mem[3], env_mem[2], env_mem[1], env_mem[0]}, 32'hDEADBEEF);

    // Req1 pulses valid only during RESP of a req0 load: must be ignored.
    acc0 = acc_cyc.size(); rsp1_0 = rsp1_cnt;
    @(posedge clk); #1;
    set_req(0, 32'h10000002, 32'h0, 1'b0, 2'b01, 1'b0);
    set_req(1, 32'h10000000, 32'h0, 1'b0, 2'b10, 1'b0);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !req_ready[0]; k++) @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1 req_valid[1] = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("resp_pulse_accepts", 32'(acc_cyc.size() - acc0), 32'h1);
    chk("resp_pulse_no_rsp1", 32'(rsp1_cnt - rsp1_0), 32'h0);
    chk("lhu_rdata", rsp_rdata, 32'h0000DEAD);

    // Reset pulse during the ACCESS of a store aborts it and clears the pointer.
    @(posedge clk); #1;
    set_req(0, 32'h10000008, 32'h12345678, 1'b1, 2'b10, 1'b0);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 20 && !req_ready[0]; k++) @(negedge clk);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    #1 rst_ni = 1'b0;
    #1 rst_ni = 1'b1;
    rsp1_0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) rsp1_0++;
    end
    chk("abort_no_rsp", 32'(rsp1_0), 32'h0);
    chk("abort_no_write", {env_mem[11], env_mem[10], env_mem[9], env_mem[8]}, 32'h0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    set_req(0, 32'h10000008, 32'h0, 1'b0, 2'b10, 1'b0);
    set_req(1, 32'h10000008, 32'h0, 1'b0, 2'b10, 1'b0);
    req_valid = 2'b11;
    @(negedge clk);
    chk("post_reset_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Both requesters valid continuously from reset: strict alternation.
    @(posedge clk); #1;
    rst_ni = 1'b0;
    set_req(0, 32'h10000000, 32'h0, 1'b0, 2'b10, 1'b0);
    set_req(1, 32'h10000004, 32'h0, 1'b0, 2'b10, 1'b0);
    req_valid = 2'b11;
    acc_cyc.delete(); acc_own.delete();
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (13) @(negedge clk);
    req_valid = 2'b00;
    chk("rr_count_ge4", 32'(acc_cyc.size() >= 4), 32'h1);
    if (acc_cyc.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("rr_owner", 32'(acc_own[k]), 32'(k % 2));
      for (int k = 1; k < 4; k++) chk("rr_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'h3);
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
